itrace_ring: RTL
================

# itrace_ring

Retired-instruction trace buffer at the writeback end of the NPC pipeline. It consumes the W-stage instruction word and PC produced by the instruction-trace pipeline, and records the last DEPTH commits in a circular buffer. On a trap or abort the buffer freezes and can be drained oldest-first over a valid/ready port for the simulation harness's itrace dump. It also keeps a 64-bit retired-instruction counter.

## Interface
- DEPTH, 16, number of ring entries; power of two, ≥ 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- commit_valid  in  1  a W-stage instruction retires this cycle.
- instr_W_TR  in  32  instruction word of the retiring instruction.
- PC_reg_WB  in  32  PC of the retiring instruction.
- freeze  in  1  trap/abort event; stops recording.
- dump_req  in  1  level; requests the drain while frozen.
- dump_ready  in  1  consumer accepts the current dump beat.
- dump_valid  out  1  dump beat present.
- dump_pc  out  32  PC of the current beat; 0 when !dump_valid.
- dump_instr  out  32  instruction of the current beat; 0 when !dump_valid.
- dump_last  out  1  current beat is the newest entry.
- dump_done  out  1  drain complete; level.
- frozen  out  1  high in every state except RECORD.
- ring_count  out  AW+1  valid entries, 0..DEPTH.
- retire_cnt  out  64  total commits since reset.

## Operation
- States: RECORD → FROZEN → DUMP → DONE. Reset enters RECORD.
- RECORD, commit_valid=1: entry[wptr] ← {PC_reg_WB, instr_W_TR}, wptr ← wptr+1 (wraps mod DEPTH), ring_count ← min(ring_count+1, DEPTH). On overflow the oldest entry is overwritten.
- RECORD, freeze=1: next state is FROZEN. A commit in the same cycle is still recorded, so the trapping instruction is kept.
- Outside RECORD: commits are not recorded, and wptr and ring_count hold.
- FROZEN, dump_req=1: next state is DUMP, with rptr ← (wptr − ring_count) mod DEPTH and remaining ← ring_count. If ring_count=0, the next state is DONE and no beat is produced.
- dump_req in RECORD is ignored. freeze and dump_req together in RECORD go to FROZEN only; a held dump_req then starts DUMP the following cycle.
- DUMP: dump_valid=1 and the data is entry[rptr]. dump_last = (remaining==1).
  - On dump_valid & dump_ready: rptr++ (wraps), remaining−−.
  - After the last handshake the next state is DONE.
- DONE: dump_done=1, dump_valid=0. Holds until rst.
- retire_cnt increments on every commit_valid in every state and wraps at 2^64.
- rst in any state, including mid-dump, returns to RECORD with wptr=0, ring_count=0, retire_cnt=0. Entry contents are left stale but are unreachable.

## Timing
- Reset values: dump_valid=0, dump_pc=0, dump_instr=0, dump_last=0, dump_done=0, frozen=0, ring_count=0, retire_cnt=0.
- A write becomes visible in ring_count the cycle after the commit.
- freeze is reflected on frozen the next cycle.
- FROZEN with dump_req: the first dump_valid appears 1 cycle later.
- Dump read is combinational from the array at rptr. A new beat follows every cycle while dump_ready=1, giving back-to-back throughput.
- With dump_valid=1 and dump_ready=0, dump_pc, dump_instr and dump_last hold stable.
- A full drain of N entries with dump_ready tied high takes N cycles in DUMP, then DONE.

## Configuration
- ITRACE_CYCLE_STAMP_EN defined:
  - A 32-bit free-running cycle counter runs from reset (0 in the reset cycle).
  - Each entry also stores the counter value at commit.
  - Output port dump_cycle (32) carries it, with the same validity and zeroing rules as dump_pc.
- Not defined: no counter, no extra storage, no dump_cycle port.

## Structure
- Package itrace_pkg:
  - state enum (RECORD, FROZEN, DUMP, DONE);
  - ITRACE_PC_W=32, ITRACE_INSTR_W=32;
  - entry struct typedef, including the cycle field under the macro.
- Sub-module itrace_ring_mem: DEPTH × entry storage with one synchronous write port and one asynchronous read port.
- The FSM, pointers and counters live in itrace_ring.

## Test plan
- DEPTH=4, 3 commits (PC 0x80000000/04/08), freeze, dump_req, ready high → 3 beats in PC order, dump_last on 0x80000008, then dump_done=1.
- 6 commits PC 0x80000000..0x80000014 into DEPTH=4 → ring_count=4; drain yields 0x80000008, 0x8000000C, 0x80000010, 0x80000014 (wrap-around and overwrite).
- Freeze with a same-cycle commit of PC 0x80000100 → that entry is the last beat. Later commits leave ring_count unchanged, while retire_cnt still increments.
- Freeze with ring_count=0, then dump_req → no dump_valid and dump_done the next cycle.
- Toggle dump_ready 1,0,0,1 during a drain → data holds during stalls, no beat is lost or duplicated. rst asserted mid-DUMP → all outputs at reset values the next cycle.
- With ITRACE_CYCLE_STAMP_EN, commits at cycles 5 and 9 → dump_cycle reads 5 then 9.

Source files
------------

// File: rtl/itrace_ring_pkg.sv
// Shared types for the retired-instruction trace ring.
// The ITRACE_CYCLE_STAMP_EN macro adds a per-entry cycle stamp field.
package itrace_pkg;

    localparam int ITRACE_PC_W    = 32;
    localparam int ITRACE_INSTR_W = 32;

    typedef enum logic [1:0] {
        RECORD = 2'd0,
        FROZEN = 2'd1,
        DUMP   = 2'd2,
        DONE   = 2'd3
    } state_e;

    typedef struct packed {
`ifdef ITRACE_CYCLE_STAMP_EN
        logic [31:0]               cycle;
`endif
        logic [ITRACE_PC_W-1:0]    pc;
        logic [ITRACE_INSTR_W-1:0] instr;
    } entry_t;

endpackage

// File: rtl/itrace_ring_if.sv
// Commit and dump handshake bundle between the pipeline/harness and the trace ring.
// dump_cycle exists only when ITRACE_CYCLE_STAMP_EN is defined.
interface itrace_ring_if;

    logic                                 commit_valid;
    logic [itrace_pkg::ITRACE_INSTR_W-1:0] instr_W_TR;
    logic [itrace_pkg::ITRACE_PC_W-1:0]    PC_reg_WB;
    logic                                 freeze;
    logic                                 dump_req;
    logic                                 dump_ready;
    logic                                 dump_valid;
    logic [itrace_pkg::ITRACE_PC_W-1:0]    dump_pc;
    logic [itrace_pkg::ITRACE_INSTR_W-1:0] dump_instr;
    logic                                 dump_last;
    logic                                 dump_done;
`ifdef ITRACE_CYCLE_STAMP_EN
    logic [31:0]                          dump_cycle;
`endif

    modport master (
        output commit_valid, instr_W_TR, PC_reg_WB, freeze, dump_req, dump_ready,
`ifdef ITRACE_CYCLE_STAMP_EN
        input  dump_cycle,
`endif
        input  dump_valid, dump_pc, dump_instr, dump_last, dump_done
    );

    modport slave (
        input  commit_valid, instr_W_TR, PC_reg_WB, freeze, dump_req, dump_ready,
`ifdef ITRACE_CYCLE_STAMP_EN
        output dump_cycle,
`endif
        output dump_valid, dump_pc, dump_instr, dump_last, dump_done
    );

endinterface

// File: rtl/itrace_ring_mem.sv
// Trace entry storage: one synchronous write port, one combinational read port.
// Contents are intentionally not reset; the pointers decide what is reachable.
module itrace_ring_mem
    import itrace_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  entry_t        i_wdata,
    input  logic [AW-1:0] i_raddr,
    output entry_t        o_rdata
);

    entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/itrace_ring.sv
// Retired-instruction trace ring: records the last DEPTH commits, freezes on trap,
// drains oldest-first. ITRACE_CYCLE_STAMP_EN adds a cycle stamp and dump_cycle.
module itrace_ring
    import itrace_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    itrace_ring_if.slave  bus,
    output logic          o_frozen,
    output logic [AW:0]   o_ring_count,
    output logic [63:0]   o_retire_cnt
);

    state_e        r_state;
    state_e        w_next_state;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [AW:0]   r_remaining;
    logic [63:0]   r_retire;
    logic          w_rec;
    logic          w_load;
    logic          w_beat;
    entry_t        w_wdata;
    entry_t        w_rdata;
`ifdef ITRACE_CYCLE_STAMP_EN
    logic [31:0]   r_cycle;
`endif

    // The freeze cycle is still RECORD, so a trapping commit is kept.
    assign w_rec  = bus.commit_valid && (r_state == RECORD);
    assign w_load = (r_state == FROZEN) && bus.dump_req;
    assign w_beat = (r_state == DUMP) && bus.dump_ready;

    always_comb begin
        w_wdata       = '0;
        w_wdata.pc    = bus.PC_reg_WB;
        w_wdata.instr = bus.instr_W_TR;
`ifdef ITRACE_CYCLE_STAMP_EN
        w_wdata.cycle = r_cycle;
`endif
    end

    itrace_ring_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .i_we    (w_rec),
        .i_waddr (r_wptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RECORD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RECORD: if (bus.freeze) w_next_state = FROZEN;
            FROZEN: if (bus.dump_req) w_next_state = (r_count == '0) ? DONE : DUMP;
            DUMP:   if (bus.dump_ready && (r_remaining == (AW+1)'(1))) w_next_state = DONE;
            DONE:   w_next_state = DONE;
            default: w_next_state = RECORD;
        endcase
    end

    // With a full ring, count[AW-1:0] is zero and the oldest entry sits at wptr.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_remaining <= '0;
            r_retire    <= '0;
        end else begin
            if (bus.commit_valid) begin
                r_retire <= r_retire + 64'd1;
            end
            if (w_rec) begin
                r_wptr <= r_wptr + AW'(1);
                if (r_count != (AW+1)'(DEPTH)) begin
                    r_count <= r_count + (AW+1)'(1);
                end
            end
            if (w_load) begin
                r_rptr      <= r_wptr - r_count[AW-1:0];
                r_remaining <= r_count;
            end else if (w_beat) begin
                r_rptr      <= r_rptr + AW'(1);
                r_remaining <= r_remaining - (AW+1)'(1);
            end
        end
    end

`ifdef ITRACE_CYCLE_STAMP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end
`endif

    always_comb begin
        bus.dump_valid = (r_state == DUMP);
        bus.dump_done  = (r_state == DONE);
        bus.dump_pc    = '0;
        bus.dump_instr = '0;
        bus.dump_last  = 1'b0;
`ifdef ITRACE_CYCLE_STAMP_EN
        bus.dump_cycle = '0;
`endif
        if (r_state == DUMP) begin
            bus.dump_pc    = w_rdata.pc;
            bus.dump_instr = w_rdata.instr;
            bus.dump_last  = (r_remaining == (AW+1)'(1));
`ifdef ITRACE_CYCLE_STAMP_EN
            bus.dump_cycle = w_rdata.cycle;
`endif
        end
    end

    assign o_frozen     = (r_state != RECORD);
    assign o_ring_count = r_count;
    assign o_retire_cnt = r_retire;

endmodule
